// File: rtl/division.sv
// ============================================================================
//  Module   : division
//  Purpose  : Sequential 32-bit restoring divider (one quotient bit per clock)
//             with a work/endSignal handshake. Result is packed {rem, quo}.
//             Define DIVISION_SIGNED_EN to add the isSigned port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module division (
    input  logic        Clk,
    input  logic        reset,
    input  logic        work,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
`ifdef DIVISION_SIGNED_EN
    input  logic        isSigned,
`endif
    output logic [63:0] result,
    output logic        endSignal,
    output logic        divByZero,
    output logic [5:0]  counter
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        dbz_q, dbz_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic        w_signed;
    logic [31:0] w_lhs_mag;
    logic [31:0] w_rhs_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;

`ifdef DIVISION_SIGNED_EN
    assign w_signed = isSigned;
`else
    assign w_signed = 1'b0;
`endif

    // Signed mode divides magnitudes; 32'h80000000 maps onto itself, which is
    // still the correct unsigned magnitude.
    assign w_lhs_mag = (w_signed && lhs[31]) ? (~lhs + 32'd1) : lhs;
    assign w_rhs_mag = (w_signed && rhs[31]) ? (~rhs + 32'd1) : rhs;

    // The 33-bit partial remainder only exists transiently after the shift.
    assign w_shift     = {rem_q, quo_q[31]};
    assign w_diff      = w_shift - {1'b0, div_q};
    assign w_rem_next  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_next  = {quo_q[30:0], ~w_diff[32]};
    assign w_quo_final = neg_quo_q ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_final = neg_rem_q ? (~w_rem_next + 32'd1) : w_rem_next;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        dbz_d     = dbz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE: begin
                result_d = 64'd0;
                dbz_d    = 1'b0;
                cnt_d    = 6'd0;
                if (work) begin
                    if (rhs == 32'd0) begin
                        result_d = {lhs, 32'hFFFF_FFFF};
                        dbz_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rem_d     = 32'd0;
                        quo_d     = w_lhs_mag;
                        div_d     = w_rhs_mag;
                        neg_quo_d = w_signed && (lhs[31] ^ rhs[31]);
                        neg_rem_d = w_signed && lhs[31];
                        state_d   = BUSY;
                    end
                end
            end

            BUSY: begin
                if (!work) begin
                    rem_d     = 32'd0;
                    quo_d     = 32'd0;
                    div_d     = 32'd0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    cnt_d     = 6'd0;
                    result_d  = 64'd0;
                    state_d   = IDLE;
                end else begin
                    rem_d = w_rem_next;
                    quo_d = w_quo_next;
                    if (cnt_q == 6'd31) begin
                        result_d = {w_rem_final, w_quo_final};
                        cnt_d    = 6'd0;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end

            DONE: begin
                if (!work) begin
                    result_d = 64'd0;
                    dbz_d    = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                result_d = 64'd0;
                dbz_d    = 1'b0;
                cnt_d    = 6'd0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            cnt_q     <= 6'd0;
            result_q  <= 64'd0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign result    = result_q;
    assign endSignal = (state_q != BUSY);
    assign divByZero = dbz_q;
    assign counter   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_division.sv
// ============================================================================
//  Module   : tb_division
//  Purpose  : Scoreboard bench for division: directed vectors push expected
//             {divByZero, result}; a monitor pops on each completion event.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_division;

    logic        Clk;
    logic        reset;
    logic        work;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        isSigned;
    logic [63:0] result;
    logic        endSignal;
    logic        divByZero;
    logic [5:0]  counter;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    logic [64:0] sb[$];

    division dut (
        .Clk       (Clk),
        .reset     (reset),
        .work      (work),
        .lhs       (lhs),
        .rhs       (rhs),
`ifdef DIVISION_SIGNED_EN
        .isSigned  (isSigned),
`endif
        .result    (result),
        .endSignal (endSignal),
        .divByZero (divByZero),
        .counter   (counter)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Completion event: endSignal rising (normal, abort, reset) or divByZero rising.
    logic prev_end = 1'b1;
    logic prev_dbz = 1'b0;
    always @(negedge Clk) begin
        if (mon_en) begin
            if ((endSignal && !prev_end) || (divByZero && !prev_dbz)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", {divByZero, result}, 65'h1_DEAD_DEAD_DEAD_DEAD);
                end else begin
                    chk("sb_result", {divByZero, result}, sb.pop_front());
                end
            end
            prev_end = endSignal;
            prev_dbz = divByZero;
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp_res, input logic exp_dbz);
        bit ok;
        @(negedge Clk);
        lhs = a; rhs = b; isSigned = sgn; work = 1'b1;
        sb.push_back({exp_dbz, exp_res});
        @(posedge Clk); #1;
        lhs = $urandom; rhs = $urandom; isSigned = ~sgn;
        if (b == 32'd0) begin
            chk("dbz_end_high", {64'd0, endSignal}, 65'd1);
            chk("dbz_flag", {64'd0, divByZero}, 65'd1);
            chk("dbz_result", {1'b0, result}, {1'b0, exp_res});
        end else begin
            ok = 1;
            for (int k = 0; k < 32; k++) begin
                if (counter !== 6'(k) || endSignal !== 1'b0) ok = 0;
                @(posedge Clk); #1;
            end
            chk("counter_sweep", {64'd0, ok}, 65'd1);
            chk("latency_end", {64'd0, endSignal}, 65'd1);
        end
    endtask

    task automatic release_op(input int hold);
        bit ok;
        logic [63:0] r0;
        r0 = result;
        ok = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            if (result !== r0 || endSignal !== 1'b1 || counter !== 6'd0) ok = 0;
        end
        if (hold > 0) chk("hold_stable", {64'd0, ok}, 65'd1);
        @(negedge Clk);
        work = 1'b0;
        @(posedge Clk); #1;
        chk("release_clear", {divByZero, result}, 65'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b0; work = 1'b0; lhs = 32'd0; rhs = 32'd0; isSigned = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_result", {1'b0, result}, 65'd0);
        chk("reset_end", {64'd0, endSignal}, 65'd1);
        chk("reset_dbz", {64'd0, divByZero}, 65'd0);
        chk("reset_counter", {59'd0, counter}, 65'd0);
        @(negedge Clk);
        reset = 1'b1;
        mon_en = 1;

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
        release_op(50);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        release_op(0);
        run_op(32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 1'b0);
        release_op(2);
        run_op(32'hDEAD_BEEF, 32'h10, 1'b0, {32'hF, 32'h0DEA_DBEE}, 1'b0);
        release_op(0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 1'b0);
        release_op(0);
        run_op(32'h1234, 32'd0, 1'b0, {32'h1234, 32'hFFFF_FFFF}, 1'b1);
        release_op(3);

        // Abort at counter == 10
        @(negedge Clk);
        lhs = 32'd1000; rhs = 32'd3; isSigned = 1'b0; work = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge Clk); #1;
            if (counter == 6'd10) seen = 1;
        end
        chk("abort_reach_10", {64'd0, seen}, 65'd1);
        @(negedge Clk);
        sb.push_back(65'd0);
        work = 1'b0;
        @(posedge Clk); #1;
        chk("abort_result", {1'b0, result}, 65'd0);
        chk("abort_idle", {58'd0, endSignal, counter}, {58'd0, 1'b1, 6'd0});

        // Reset mid-BUSY
        @(negedge Clk);
        lhs = 32'd50; rhs = 32'd3; work = 1'b1;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        sb.push_back(65'd0);
        reset = 1'b0;
        @(posedge Clk); #1;
        chk("midreset_outs", {divByZero, result}, 65'd0);
        chk("midreset_ctl", {58'd0, endSignal, counter}, {58'd0, 1'b1, 6'd0});
        @(negedge Clk);
        reset = 1'b1; work = 1'b0;
        @(posedge Clk);

`ifdef DIVISION_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        release_op(0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 1'b0);
        release_op(0);
`endif

        repeat (3) @(posedge Clk);
        #1;
        chk("sb_drained", {33'd0, 32'(sb.size())}, 65'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/division.md
# division

Sequential 32-bit integer divider for the MIPS datapath, the counterpart of the shift-and-add multiplier. It computes quotient and remainder for DIV/DIVU and packs them HI:LO style into a 64-bit result, so the control unit drives it with the same `work`/`endSignal` handshake it uses for the multiplier. It uses restoring division, one quotient bit per clock.

## Interface
- No parameters; width is fixed at 32-bit operands and a 64-bit result.
- `Clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on rising `Clk`.
- `work`  in  1  request/hold; high requests a division and must stay high until the result has been consumed.
- `lhs`  in  32  dividend; sampled only on the accept edge.
- `rhs`  in  32  divisor; sampled only on the accept edge.
- `result`  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
- `endSignal`  out  1  high when not busy (IDLE or DONE), low in BUSY.
- `divByZero`  out  1  high in DONE when the accepted divisor was 0.
- `counter`  out  6  iteration index; 0 outside BUSY.

## Operation
- States are IDLE, BUSY and DONE; the reset state is IDLE.
- IDLE:
  - `endSignal`=1, `result` holds 0, `divByZero`=0, `counter`=0.
  - With `work`=1: latch `lhs` and `rhs`. If `rhs`≠0, go to BUSY. If `rhs`=0, go directly to DONE with `divByZero`=1.
- BUSY:
  - Uses an internal 33-bit partial remainder R (init 0), a quotient register Q (init dividend) and divisor D.
  - Each cycle: shift {R,Q} left by 1, compute T = R − {1'b0,D}.
  - If T is non-negative, set R=T and Q[0]=1; otherwise restore R and set Q[0]=0.
  - `counter` increments 0→31. After the iteration with `counter`=31, load `result`={R[31:0],Q} and go to DONE.
- DONE:
  - `endSignal`=1 and `result` is held stable.
  - When `work` drops to 0, go to IDLE and clear `result` to 0.
- Divide by zero: `result`={dividend, 32'hFFFFFFFF}, `divByZero`=1.
- Abort: `work`=0 while in BUSY returns to IDLE on the next edge, clears `result`, and discards partial state.
- Arithmetic:
  - Unsigned by default.
  - Quotient = floor(lhs/rhs) and remainder = lhs − q·rhs, both exact to 32 bits.
  - No overflow is possible in unsigned mode.
- Operand changes on `lhs`/`rhs` after the accept edge have no effect.

## Timing
- Reset values (with `reset`=0 at an edge): state IDLE, `result`=64'd0, `endSignal`=1, `divByZero`=0, `counter`=6'd0. Reset overrides `work` in every state, including mid-BUSY.
- Accept edge A: the first edge in IDLE with `work`=1. `endSignal` goes to 0 after A.
- Normal latency: `result` is valid and `endSignal`=1 after edge A+32, i.e. 32 BUSY cycles. `counter` reads k during the (k+1)-th BUSY cycle.
- Divide-by-zero latency: DONE after edge A; `endSignal` never drops.
- A new operation needs at least one IDLE cycle: `work` low for one edge, then high again. Holding `work` high in DONE never restarts the divider.
- `divByZero` clears on the DONE→IDLE transition.

## Configuration
- `DIVISION_SIGNED_EN` defined: an extra port `isSigned` (in, 1 bit) is added and sampled at accept.
  - With `isSigned`=1, magnitudes are divided. The quotient is negated when operand signs differ; the remainder takes the dividend's sign.
  - 32'h80000000 / 32'hFFFFFFFF gives quotient 32'h80000000, remainder 0.
  - Divide by zero still gives {dividend, 32'hFFFFFFFF}.
  - Sign fix-up happens on the final BUSY edge; latency is unchanged.
- `DIVISION_SIGNED_EN` undefined: there is no `isSigned` port and all division is unsigned.

## Test plan
- Basic: reset, then `lhs`=100, `rhs`=7, `work`=1 → after 32 BUSY cycles `result`={32'd2, 32'd14}, `endSignal` 0→1, `counter` sweeps 0..31.
- Max values: `lhs`=32'hFFFFFFFF, `rhs`=1 → `result`={0, 32'hFFFFFFFF}. Then `lhs`=5, `rhs`=9 → `result`={5, 0}.
- Divide by zero: `lhs`=32'h1234, `rhs`=0 → DONE one edge after accept, `result`={32'h1234, 32'hFFFFFFFF}, `divByZero`=1, `endSignal` stays 1.
- Abort and reset: drop `work` at `counter`=10 → IDLE with `result`=0 next edge. Separately, pull `reset` low mid-BUSY → all outputs at reset values after that edge.
- Handshake: hold `work`=1 for 50 cycles after DONE → result stable, no restart. Change `lhs` during BUSY → result unaffected.
- Signed (with `DIVISION_SIGNED_EN`, `isSigned`=1): −7/2 → {32'hFFFFFFFF, 32'hFFFFFFFD}. 32'h80000000 / −1 → {0, 32'h80000000}.
